nbout_psum_ctrl: RTL and testbench
==================================

// Module: nbout_psum_ctrl
// PURPOSE
//  Output-neuron partial-sum buffer (NBout) and sequencer directly downstream of the Tn-lane adder-tree cluster.
//  Receives the cluster's Tn lanes of N-bit results and feeds partial sums back into the cluster's i_partial_sum.
//  Walks input chunks (outer loop) over output groups (inner loop); partial sums live in an internal buffer.
//  On the final chunk it streams finished Tn*N results out through a valid/ready FIFO.
// PARAMETERS
//  N        16  lane width (bits), two's-complement, wraps mod 2^N
//  Tn       16  lanes per beat
//  DEPTH    64  output groups held in NBout
//  AW       6   log2(DEPTH)
//  CW       8   chunk-count width
//  PIPE_LAT 1   cycles from i_vals accepted by cluster to cluster sampling i_partial_sum/producing o_res
//  OFIFO    4   output FIFO depth; must be >= PIPE_LAT+1
// PORTS
//  clk            in   1      single clock, all logic posedge
//  rst            in   1      synchronous, active-high reset
//  i_start        in   1      start pass; sampled only in IDLE
//  i_num_groups   in   AW+1   groups per chunk, 1..DEPTH; latched on start
//  i_num_chunks   in   CW     chunks per pass, 1..2^CW-1; latched on start
//  i_beat_valid   in   1      upstream presents one cluster beat (i_vals) this cycle
//  o_beat_ready   out  1      beat accepted when i_beat_valid && o_beat_ready
//  o_partial_sum  out  Tn*N   to cluster i_partial_sum
//  i_cluster_res  in   Tn*N   from cluster o_res
//  o_out_valid    out  1      finished group available
//  i_out_ready    in   1      consumer accepts
//  o_out_data     out  Tn*N   finished group, lane i at [(i+1)*N-1:i*N]
//  o_out_group    out  AW     group index of o_out_data
//  o_busy         out  1      high in RUN and DRAIN
//  o_done         out  1      one-cycle pulse at end of pass
// BEHAVIOUR
//  Reset: state=IDLE, counters 0, FIFO empty, pipeline valids 0; o_beat_ready=0, o_out_valid=0, o_busy=0,
//   o_done=0, o_partial_sum=0, o_out_data/o_out_group=0. NBout contents are not reset (don't care).
//  FSM IDLE -> RUN on i_start (latches counts, g=0, c=0). RUN -> DRAIN when the beat for (c=last, g=last) is accepted.
//   DRAIN -> DONE when no beats are in flight, the FIFO is empty and the last pop has occurred. DONE -> IDLE next cycle.
//   o_done=1 only in DONE. i_start outside IDLE is ignored.
//  Beat order: g increments per accepted beat; at g=num_groups-1, g wraps to 0 and c increments.
//  Tag pipeline: each accepted beat at cycle t carries {g, first=(c==0), last=(c==num_chunks-1)} through PIPE_LAT stages.
//  At t+PIPE_LAT: o_partial_sum = first ? 0 : NBout[g] (combinational read), the same cycle the cluster adds it.
//   At the same edge: if !last, NBout[g] <= i_cluster_res; if last, push {g, i_cluster_res} into the output FIFO.
//   When no tagged beat is at the stage, o_partial_sum=0.
//  Hazard: a write to NBout[g] at edge E is visible to a read at cycle E+1 (write-before-next-read).
//   This is required for num_groups=1 with back-to-back beats; no bypass mux is needed.
//  Backpressure: o_beat_ready=1 in RUN, except when the current beat is a last-chunk beat and
//   (FIFO occupancy + last-chunk beats in flight) >= OFIFO; then o_beat_ready=0.
//   Non-last beats are never stalled.
//  Output: o_out_valid = FIFO non-empty; pop on i_out_ready && o_out_valid. Data/group are held stable while valid && !ready.
//  Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
//  num_chunks=1: every beat is first and last; o_partial_sum=0 and results go straight to the FIFO.
//  rst mid-pass: immediate return to IDLE; in-flight beats and FIFO contents are discarded and no o_done is issued.
//  All arithmetic is done in the cluster; this block only moves N-bit lanes, with no width change.
// STRUCTURE
//  Shared include convpress_defs.vh: N, Tn, DEPTH, AW, state encodings (IDLE/RUN/DRAIN/DONE).
//  NBout: DEPTH x Tn*N register array with one write port and one async read port, inside this module.
//  Sub-module sync_fifo (WIDTH=AW+Tn*N, DEPTH=OFIFO): output FIFO with count output.
// TESTING
//  Testbench: behavioural cluster model (sum of beat + partial sum, PIPE_LAT register).
//  1. groups=4, chunks=3, per-lane beat value 1, out_ready=1 -> 4 outputs, each lane=3, groups 0,1,2,3, then o_done.
//  2. groups=1, chunks=5, back-to-back beats, lane k value = k -> single output, lane k=5k. Checks the RAW path.
//  3. groups=8, chunks=2, i_out_ready=0 -> o_beat_ready drops after 4 last-chunk beats are accepted/in flight.
//     Raising ready drains all 8, in order 0..7.
//  4. Lane value 0x7FFF over 2 chunks -> output 0xFFFE (wrap). Lane value 0xFFFF x3 -> 0xFFFD.
//  5. rst asserted mid-RUN (c=1, g=2) -> next cycle o_busy=0, o_out_valid=0, no o_done. A new start then runs cleanly.
//  6. i_start pulsed during RUN -> ignored; the pass completes with the original counts, exactly one o_done.

Source files
------------

// File: rtl/nbout_psum_ctrl_pkg.sv
// Shared widths, FSM encoding and payload structs for the NBout partial-sum sequencer.
package nbout_psum_ctrl_pkg;

  localparam int unsigned N       = 16;
  localparam int unsigned TN      = 16;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned AW      = 6;
  localparam int unsigned CW      = 8;
  localparam int unsigned GW      = AW + 1;
  localparam int unsigned LANES_W = TN * N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Per-beat tag travelling alongside the cluster pipeline
  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [AW-1:0] group;
  } tag_t;

  // Output FIFO entry
  typedef struct packed {
    logic [AW-1:0]      group;
    logic [LANES_W-1:0] data;
  } out_entry_t;

endpackage

// File: rtl/nbout_psum_ctrl_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is visible combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNTW-1:0]  count,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when a pop frees a slot in the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nbout_psum_ctrl.sv
// NBout partial-sum buffer and chunk/group sequencer feeding the adder-tree cluster.
module nbout_psum_ctrl
  import nbout_psum_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 1,
  parameter int unsigned OFIFO    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [GW-1:0]      i_num_groups,
  input  logic [CW-1:0]      i_num_chunks,
  input  logic               i_beat_valid,
  output logic               o_beat_ready,
  output logic [LANES_W-1:0] o_partial_sum,
  input  logic [LANES_W-1:0] i_cluster_res,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [LANES_W-1:0] o_out_data,
  output logic [AW-1:0]      o_out_group,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned CNTW = $clog2(OFIFO + 1);

  state_t             state;
  state_t             state_next;
  logic [GW-1:0]      num_groups;
  logic [CW-1:0]      num_chunks;
  logic [AW-1:0]      grp;
  logic [CW-1:0]      chunk;
  tag_t               tag_pipe [PIPE_LAT];
  tag_t               stage;
  logic [LANES_W-1:0] nbout [DEPTH];

  logic               grp_last;
  logic               chunk_last;
  logic               beat_fire;
  logic               pipe_empty;
  logic [7:0]         inflight_last;
  logic [7:0]         occupancy;

  out_entry_t         fifo_in;
  out_entry_t         fifo_head;
  logic [CNTW-1:0]    fifo_count;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;

  assign stage      = tag_pipe[PIPE_LAT-1];
  assign grp_last   = ({1'b0, grp} == (num_groups - GW'(1)));
  assign chunk_last = (chunk == (num_chunks - CW'(1)));
  assign beat_fire  = i_beat_valid && o_beat_ready;

  // Count last-chunk beats still in the cluster pipe and whether the pipe is idle
  always_comb begin
    inflight_last = '0;
    pipe_empty    = 1'b1;
    for (int i = 0; i < int'(PIPE_LAT); i++) begin
      if (tag_pipe[i].valid) pipe_empty = 1'b0;
      if (tag_pipe[i].valid && tag_pipe[i].last) inflight_last = inflight_last + 8'd1;
    end
  end

  // Only last-chunk beats can be stalled, so FIFO slots are reserved before they are issued
  assign occupancy    = 8'(fifo_count) + inflight_last;
  assign o_beat_ready = (state == ST_RUN) && !(chunk_last && (occupancy >= 8'(OFIFO)));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start) state_next = ST_RUN;
      ST_RUN:   if (beat_fire && chunk_last && grp_last) state_next = ST_DRAIN;
      ST_DRAIN: if (pipe_empty && fifo_empty) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign o_busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign o_done = (state == ST_DONE);

  // Pass configuration and group/chunk walk (groups inner, chunks outer)
  always_ff @(posedge clk) begin
    if (rst) begin
      num_groups <= '0;
      num_chunks <= '0;
      grp        <= '0;
      chunk      <= '0;
    end else if (state == ST_IDLE && i_start) begin
      num_groups <= i_num_groups;
      num_chunks <= i_num_chunks;
      grp        <= '0;
      chunk      <= '0;
    end else if (beat_fire) begin
      if (grp_last) begin
        grp   <= '0;
        chunk <= chunk + CW'(1);
      end else begin
        grp <= grp + AW'(1);
      end
    end
  end

  // Tag pipeline aligned with the cluster's latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: beat_fire, first: (chunk == '0), last: chunk_last, group: grp};
      for (int i = 1; i < int'(PIPE_LAT); i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Partial sum for the beat at the cluster's add stage; zero on the first chunk
  assign o_partial_sum = (stage.valid && !stage.first) ? nbout[stage.group] : '0;

  // NBout write-back of non-final sums; visible to the following cycle's read
  always_ff @(posedge clk) begin
    if (!rst && stage.valid && !stage.last) nbout[stage.group] <= i_cluster_res;
  end

  assign fifo_push = stage.valid && stage.last;
  assign fifo_in   = '{group: stage.group, data: i_cluster_res};
  assign fifo_pop  = o_out_valid && i_out_ready;

  sync_fifo #(
    .WIDTH ($bits(out_entry_t)),
    .DEPTH (OFIFO)
  ) u_ofifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_in),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Head entry is presented only while valid so idle outputs read zero
  assign o_out_valid = !fifo_empty;
  assign o_out_data  = o_out_valid ? fifo_head.data  : '0;
  assign o_out_group = o_out_valid ? fifo_head.group : '0;

endmodule

// File: tb/tb_nbout_psum_ctrl.sv
// Self-checking bench: behavioural cluster model plus per-group sum reference.
module tb_nbout_psum_ctrl;
  import nbout_psum_ctrl_pkg::*;

  localparam int unsigned LW = LANES_W;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_start;
  logic [GW-1:0]  i_num_groups;
  logic [CW-1:0]  i_num_chunks;
  logic           i_beat_valid;
  logic           o_beat_ready;
  logic [LW-1:0]  o_partial_sum;
  logic [LW-1:0]  i_cluster_res;
  logic           o_out_valid;
  logic           i_out_ready;
  logic [LW-1:0]  o_out_data;
  logic [AW-1:0]  o_out_group;
  logic           o_busy;
  logic           o_done;

  int errors = 0;
  int checks = 0;

  logic [LW-1:0] beat_vals;
  logic [LW-1:0] vals_d = '0;
  logic [LW-1:0] stim [256];

  logic [LW-1:0] obs_data [$];
  logic [AW-1:0] obs_group [$];
  int            done_cnt;
  int            beats_at_release;
  logic          ready_at_release;

  always #5 clk = ~clk;

  nbout_psum_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_num_groups  (i_num_groups),
    .i_num_chunks  (i_num_chunks),
    .i_beat_valid  (i_beat_valid),
    .o_beat_ready  (o_beat_ready),
    .o_partial_sum (o_partial_sum),
    .i_cluster_res (i_cluster_res),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_data    (o_out_data),
    .o_out_group   (o_out_group),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  // Cluster model: one-cycle register of the beat, then lane-wise add of the partial sum
  always_ff @(posedge clk) begin
    if (i_beat_valid && o_beat_ready) vals_d <= beat_vals;
  end

  always_comb begin
    i_cluster_res = '0;
    for (int l = 0; l < int'(TN); l++)
      i_cluster_res[l*N +: N] = vals_d[l*N +: N] + o_partial_sum[l*N +: N];
  end

  // Reference: final value of group g is the wrapped lane-wise sum of its beats over all chunks
  function automatic logic [LW-1:0] model_group(input int ng, input int nc, input int g);
    logic [LW-1:0] r;
    logic [N-1:0]  acc;
    r = '0;
    for (int l = 0; l < int'(TN); l++) begin
      acc = '0;
      for (int c = 0; c < nc; c++) acc = acc + stim[c*ng + g][l*N +: N];
      r[l*N +: N] = acc;
    end
    return r;
  endfunction

  function automatic logic [LW-1:0] splat(input logic [N-1:0] v);
    logic [LW-1:0] r;
    for (int l = 0; l < int'(TN); l++) r[l*N +: N] = v;
    return r;
  endfunction

  task automatic fill_random(input int beats);
    for (int b = 0; b < beats; b++)
      for (int l = 0; l < int'(TN); l++) stim[b][l*N +: N] = N'($urandom);
  endtask

  // Runs one pass and records every popped output and every o_done pulse
  task automatic drive_pass(input int ng, input int nc, input int valid_pct, input int ready_pct,
                            input int hold_cycles, input int restart_at, output bit timed_out);
    int beat;
    int cyc;
    int tail;
    bit restarted;
    beat = 0; cyc = 0; tail = 0; restarted = 0; timed_out = 0;
    obs_data.delete();
    obs_group.delete();
    done_cnt = 0;
    @(negedge clk);
    i_num_groups = GW'(ng);
    i_num_chunks = CW'(nc);
    i_start = 1'b1;
    @(negedge clk);
    while (tail < 4) begin
      i_start = 1'b0;
      if (restart_at >= 0 && beat == restart_at && !restarted) begin
        i_start      = 1'b1;
        i_num_groups = GW'((ng == 1) ? 3 : 1);
        i_num_chunks = CW'(nc + 2);
        restarted    = 1;
      end
      if (beat < ng*nc) begin
        i_beat_valid = ($urandom_range(99) < 32'(valid_pct));
        beat_vals    = stim[beat];
      end else begin
        i_beat_valid = 1'b0;
        beat_vals    = '0;
      end
      i_out_ready = (cyc >= hold_cycles) && ($urandom_range(99) < 32'(ready_pct));
      if (hold_cycles > 0 && cyc == hold_cycles) begin
        beats_at_release = beat;
        ready_at_release = o_beat_ready;
      end
      #1;
      if (o_done) done_cnt++;
      if (i_beat_valid && o_beat_ready) beat++;
      if (o_out_valid && i_out_ready) begin
        obs_data.push_back(o_out_data);
        obs_group.push_back(o_out_group);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done_cnt > 0) tail++;
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
    end
    i_start = 1'b0;
    i_beat_valid = 1'b0;
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_beat_ready !== 1'b0) begin errors++; $display("FAIL reset_beat_ready: got %b want 0", o_beat_ready); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", o_out_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
    checks++; if (o_partial_sum !== '0) begin errors++; $display("FAIL reset_psum: got %h want 0", o_partial_sum); end
    checks++; if (o_out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", o_out_data); end
    checks++; if (o_out_group !== '0) begin errors++; $display("FAIL reset_out_group: got %h want 0", o_out_group); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    for (int b = 0; b < 12; b++) stim[b] = splat(N'(1));
    drive_pass(4, 3, 100, 100, 0, -1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", to); end
    checks++; if (obs_data.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 4; i++) begin
      checks++; if (obs_group[i] !== AW'(i)) begin errors++; $display("FAIL basic_group[%0d]: got %0d want %0d", i, obs_group[i], i); end
      checks++; if (obs_data[i] !== splat(N'(3))) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, obs_data[i], splat(N'(3))); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_raw_single_group();
    bit to;
    logic [LW-1:0] want;
    for (int b = 0; b < 5; b++)
      for (int l = 0; l < int'(TN); l++) stim[b][l*N +: N] = N'(l);
    for (int l = 0; l < int'(TN); l++) want[l*N +: N] = N'(5*l);
    drive_pass(1, 5, 100, 100, 0, -1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL raw_timeout: got %b want 0", to); end
    checks++; if (obs_data.size() !== 1) begin errors++; $display("FAIL raw_count: got %0d want 1", obs_data.size()); end
    if (obs_data.size() > 0) begin
      checks++; if (obs_data[0] !== want) begin errors++; $display("FAIL raw_data: got %h want %h", obs_data[0], want); end
      checks++; if (obs_group[0] !== '0) begin errors++; $display("FAIL raw_group: got %0d want 0", obs_group[0]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL raw_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit to;
    fill_random(16);
    beats_at_release = -1;
    ready_at_release = 1'bx;
    drive_pass(8, 2, 100, 100, 40, -1, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b want 0", to); end
    checks++; if (beats_at_release !== 12) begin errors++; $display("FAIL bp_beats_held: got %0d want 12", beats_at_release); end
    checks++; if (ready_at_release !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %b want 0", ready_at_release); end
    checks++; if (obs_data.size() !== 8) begin errors++; $display("FAIL bp_count: got %0d want 8", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 8; i++) begin
      checks++; if (obs_group[i] !== AW'(i)) begin errors++; $display("FAIL bp_group[%0d]: got %0d want %0d", i, obs_group[i], i); end
      checks++; if (obs_data[i] !== model_group(8, 2, i)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, obs_data[i], model_group(8, 2, i)); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    bit to;
    for (int b = 0; b < 4; b++) stim[b] = splat(16'h7FFF);
    drive_pass(2, 2, 100, 100, 0, -1, to);
    checks++; if (obs_data.size() !== 2 || to) begin errors++; $display("FAIL wrap1_count: got %0d want 2", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 2; i++) begin
      checks++; if (obs_data[i] !== splat(16'hFFFE)) begin errors++; $display("FAIL wrap1_data[%0d]: got %h want %h", i, obs_data[i], splat(16'hFFFE)); end
    end
    for (int b = 0; b < 3; b++) stim[b] = splat(16'hFFFF);
    drive_pass(1, 3, 100, 100, 0, -1, to);
    checks++; if (obs_data.size() !== 1 || to) begin errors++; $display("FAIL wrap2_count: got %0d want 1", obs_data.size()); end
    if (obs_data.size() > 0) begin
      checks++; if (obs_data[0] !== splat(16'hFFFD)) begin errors++; $display("FAIL wrap2_data: got %h want %h", obs_data[0], splat(16'hFFFD)); end
    end
  endtask

  task automatic test_reset_mid_run();
    int beat;
    int cyc;
    int dones;
    bit to;
    for (int b = 0; b < 12; b++) stim[b] = splat(N'(1));
    @(negedge clk);
    i_num_groups = GW'(4);
    i_num_chunks = CW'(3);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    beat = 0; cyc = 0;
    while (beat < 6 && cyc < 50) begin
      i_beat_valid = 1'b1;
      beat_vals = stim[beat];
      i_out_ready = 1'b1;
      #1;
      if (o_beat_ready) beat++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    checks++; if (beat !== 6) begin errors++; $display("FAIL rstmid_reach: got %0d beats want 6", beat); end
    rst = 1'b1;
    i_beat_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", o_out_valid); end
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_done) dones++;
      @(negedge clk);
      #1;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
    fill_random(6);
    drive_pass(3, 2, 80, 80, 0, -1, to);
    checks++; if (obs_data.size() !== 3 || to) begin errors++; $display("FAIL rstmid_rerun_count: got %0d want 3", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 3; i++) begin
      checks++; if (obs_data[i] !== model_group(3, 2, i) || obs_group[i] !== AW'(i)) begin
        errors++; $display("FAIL rstmid_rerun[%0d]: got g%0d %h want g%0d %h", i, obs_group[i], obs_data[i], i, model_group(3, 2, i));
      end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    fill_random(15);
    drive_pass(5, 3, 100, 100, 0, 4, to);
    checks++; if (obs_data.size() !== 5 || to) begin errors++; $display("FAIL restart_count: got %0d want 5", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 5; i++) begin
      checks++; if (obs_data[i] !== model_group(5, 3, i) || obs_group[i] !== AW'(i)) begin
        errors++; $display("FAIL restart_data[%0d]: got g%0d %h want g%0d %h", i, obs_group[i], obs_data[i], i, model_group(5, 3, i));
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random_passes();
    bit to;
    int ng;
    int nc;
    for (int p = 0; p < 6; p++) begin
      ng = (p == 0) ? 3 : int'($urandom_range(1, 8));
      nc = (p == 0) ? 1 : int'($urandom_range(1, 4));
      fill_random(ng*nc);
      drive_pass(ng, nc, 70, 60, 0, -1, to);
      checks++; if (obs_data.size() !== ng || to) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", p, obs_data.size(), ng); end
      for (int i = 0; i < obs_data.size() && i < ng; i++) begin
        checks++; if (obs_data[i] !== model_group(ng, nc, i) || obs_group[i] !== AW'(i)) begin
          errors++; $display("FAIL rand%0d_data[%0d]: got g%0d %h want g%0d %h", p, i, obs_group[i], obs_data[i], i, model_group(ng, nc, i));
        end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand%0d_done: got %0d want 1", p, done_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_num_groups = '0;
    i_num_chunks = '0;
    i_beat_valid = 1'b0;
    i_out_ready = 1'b0;
    beat_vals = '0;
    test_reset();
    test_basic();
    test_raw_single_group();
    test_backpressure();
    test_wrap();
    test_reset_mid_run();
    test_start_ignored();
    test_random_passes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
